// File: rtl/toggle_cover_source_pkg.sv
`default_nettype none
// ============================================================================
// Module      : toggle_cover_pkg
// Description : Shared definitions for the toggle-coverage path. Holds the
//               cover index width, the event serializer state encoding and
//               the design-wide cover point total. It is shared by the
//               producer (toggle_cover_source) and the coverage collector.
// Revision    : 1.0 - initial release
// ============================================================================
package toggle_cover_pkg;

    // Width of an absolute cover index as carried on the event stream.
    localparam int unsigned COVER_IDX_W = 64;

    // Total cover points in the design. Only used for an elaboration-time
    // range check on each source instance.
    localparam int unsigned COVER_TOTAL_DEFAULT = 8065;

    // Event serializer states.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } tc_ser_state_e;

endpackage : toggle_cover_pkg
`default_nettype wire

// File: rtl/toggle_cover_source_if.sv
`default_nettype none
// ============================================================================
// Module      : toggle_cover_source_if
// Description : First-hit event stream between a toggle-coverage source and
//               the hardware coverage collector (valid/ready handshake).
//   evt_valid : event available (source -> collector)
//   evt_ready : collector accepts event (collector -> source)
//   evt_index : absolute cover index of the event (source -> collector)
//   Modports  : master = source side, slave = collector side
// Revision    : 1.0 - initial release
// ============================================================================
interface toggle_cover_source_if;
    import toggle_cover_pkg::*;

    logic                   evt_valid;
    logic                   evt_ready;
    logic [COVER_IDX_W-1:0] evt_index;

    modport master (
        output evt_valid,
        output evt_index,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_index,
        output evt_ready
    );

endinterface : toggle_cover_source_if
`default_nettype wire

// File: rtl/toggle_cover_source_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : toggle_cover_prio_enc
// Description : Lowest-set-bit priority encoder. Purely combinational.
//   req   [WIDTH]  : request vector
//   idx   [IDX_W]  : index of the lowest set bit of req (0 when none set)
//   any   [1]      : at least one bit of req is set
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_cover_prio_enc #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  wire  [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the last match written is the lowest index.
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule : toggle_cover_prio_enc
`default_nettype wire

// File: rtl/toggle_cover_source.sv
`default_nettype none
// ============================================================================
// Module      : toggle_cover_source
// Description : Producer side of the toggle-coverage path. Samples a WIDTH-bit
//               monitored signal every cycle, pulses a per-bit toggle vector,
//               keeps a sticky hit map and serializes each first-time hit as
//               an absolute cover index on a valid/ready event stream.
//
// Ports:
//   clock            : clock
//   reset            : synchronous, active-low reset
//   enable           : sampling enable (prev still tracks sig when low)
//   clear            : re-arm; wipes hit map, pending queue and valid
//   sig     [WIDTH]  : monitored signal
//   valid   [WIDTH]  : registered one-cycle toggle pulses, bit i = point
//                      COVER_INDEX+i
//   evt              : first-hit event stream (master modport)
//   covered          : registered popcount of the hit map
//
// Configuration macro:
//   TOGGLE_COVER_FIRST_ONLY_EN : when defined, valid[i] pulses only on the
//                                first toggle of bit i since reset/clear.
//                                Hit map, serializer and covered unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_cover_source
    import toggle_cover_pkg::*;
#(
    parameter int unsigned WIDTH       = 9,
    parameter int unsigned COVER_INDEX = 0,
    parameter int unsigned COVER_TOTAL = COVER_TOTAL_DEFAULT
) (
    input  wire                         clock,
    input  wire                         reset,
    input  wire                         enable,
    input  wire                         clear,
    input  wire  [WIDTH-1:0]            sig,
    output logic [WIDTH-1:0]            valid,
    toggle_cover_source_if.master       evt,
    output logic [$clog2(WIDTH+1)-1:0]  covered
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // This instance's cover points must lie inside the design's index space.
    generate
        if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_error
            $error("toggle_cover_source: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detect and hit bookkeeping
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] prev;
    logic             primed;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] first_tog;
    logic [WIDTH-1:0] valid_nxt;
    logic [WIDTH-1:0] pop_mask;
    logic [CNT_W-1:0] hit_count;

    // Until one sample has been taken, prev holds the reset value rather than
    // a real observation, so no toggle may be derived from it.
    assign tog       = (primed && enable) ? (sig ^ prev) : '0;
    assign first_tog = tog & ~hit;

`ifdef TOGGLE_COVER_FIRST_ONLY_EN
    assign valid_nxt = first_tog;
`else
    assign valid_nxt = tog;
`endif

    always_comb begin
        hit_count = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            hit_count = hit_count + CNT_W'(hit[i]);
        end
    end

    // ------------------------------------------------------------------
    // Serializer: pick the lowest pending point
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] low_idx;
    logic             any_pending;

    toggle_cover_prio_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req (pending),
        .idx (low_idx),
        .any (any_pending)
    );

    tc_ser_state_e          state;
    tc_ser_state_e          state_nxt;
    logic [IDX_W-1:0]       cur_idx;
    logic [COVER_IDX_W-1:0] index_q;
    logic                   latch;
    logic                   pop;

    // State register; the presented index is latched on entry to PRESENT so
    // it stays stable regardless of later pending activity.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cur_idx <= '0;
            index_q <= '0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                cur_idx <= low_idx;
                index_q <= COVER_IDX_W'(COVER_INDEX) + COVER_IDX_W'(low_idx);
            end
        end
    end

    // Next-state logic. clear abandons an unaccepted event outright.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        pop       = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (any_pending) begin
                        state_nxt = PRESENT;
                        latch     = 1'b1;
                    end
                end
                PRESENT: begin
                    if (evt.evt_ready) begin
                        state_nxt = IDLE;
                        pop       = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        evt.evt_valid = (state == PRESENT);
        evt.evt_index = index_q;
    end

    // The popped bit is already in hit, so first_tog can never re-set it in
    // the same cycle; a new bit and a pop of another bit both take effect.
    assign pop_mask = pop ? (WIDTH'(1) << cur_idx) : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev    <= '0;
            primed  <= 1'b0;
            hit     <= '0;
            pending <= '0;
            valid   <= '0;
            covered <= '0;
        end else begin
            prev   <= sig;
            primed <= 1'b1;
            if (clear) begin
                // Toggles seen in the clear cycle are dropped.
                hit     <= '0;
                pending <= '0;
                valid   <= '0;
                covered <= '0;
            end else begin
                hit     <= hit | tog;
                pending <= (pending | first_tog) & ~pop_mask;
                valid   <= valid_nxt;
                covered <= hit_count;
            end
        end
    end

endmodule : toggle_cover_source
`default_nettype wire

// File: doc/toggle_cover_source.md
# toggle_cover_source

Producer side of the toggle-coverage path. Samples a monitored WIDTH-bit signal every cycle and detects per-bit toggles. Drives a per-point `valid` pulse vector for the per-point coverage reporter. Also keeps a sticky hit map and serializes each first-time hit as an absolute cover index over a valid/ready stream to the hardware coverage collector. One instance sits beside each instrumented signal group.

## Interface
- `WIDTH`, 9, number of monitored bits (one cover point each)
- `COVER_INDEX`, 0, absolute index of bit 0
- `COVER_TOTAL`, 8065, total cover points in design; used only for elaboration check `COVER_INDEX+WIDTH <= COVER_TOTAL`
- `clock` in 1: clock
- `reset` in 1: reset, synchronous, active-low; clock clock
- `enable` in 1: sampling enable; when low, no toggles detected, prev still updates
- `clear` in 1: re-arm; wipes hit map and pending queue
- `sig` in WIDTH: monitored signal
- `valid` out WIDTH: registered one-cycle toggle pulses, bit i = point COVER_INDEX+i
- `evt_valid` out 1: first-hit event available
- `evt_ready` in 1: collector accepts event
- `evt_index` out 64: absolute cover index of event
- `covered` out $clog2(WIDTH+1): popcount of hit map

## Operation
- Registers: `prev[WIDTH]`, `primed`, `hit[WIDTH]`, `pending[WIDTH]`, output regs.
- `primed` clears on reset and sets after the first clocked sample. While `primed`=0, no toggle is detected, so the first post-reset value is never a toggle.
- `tog = primed & enable ? (sig ^ prev) : 0`. `prev <= sig` every non-reset cycle.
- Set logic: `hit |= tog`. `pending |= tog & ~hit` (first hit only).
- Serializer states IDLE / PRESENT:
  - IDLE: if pending≠0, latch lowest set index j. Drive `evt_index = COVER_INDEX + j` (64-bit zero-extended add, no wrap). Assert `evt_valid`. Go to PRESENT.
  - PRESENT: `evt_index` and `evt_valid` are held stable until `evt_ready`. On the handshake, clear `pending[j]` and return to IDLE. Back-to-back events therefore use 2 cycles each.
- A pending bit set in the same cycle as a pop of a different bit: both take effect.
- `clear`: `hit`, `pending` and `valid` go to 0 and the serializer goes to IDLE. `clear` overrides an unaccepted PRESENT event; the event is dropped, a deliberate exception to the stable-until-accepted rule. `prev` and `primed` are unaffected. Toggles in the `clear` cycle are discarded.
- `covered` is a registered popcount of `hit` and saturates naturally at WIDTH.

## Timing
- Reset values: `valid`=0, `evt_valid`=0, `evt_index`=0, `covered`=0. All internal state is 0 and state is IDLE.
- `sig` changes between samples N-1 and N: `valid[i]` is high in cycle N+1 for exactly one cycle.
- The `hit` update is visible in cycle N+1 and `covered` in cycle N+2.
- Earliest `evt_valid` is cycle N+2, given IDLE with no older pending.
- Reset asserted mid-handshake: the event is lost and no partial state survives.
- Reset in the middle of toggling: the first sample after reset release is absorbed by priming.

## Configuration
- `TOGGLE_COVER_FIRST_ONLY_EN` defined: `valid[i]` pulses only on the first toggle of bit i since reset/clear, i.e. `valid <= tog & ~hit`. This reduces DPI traffic.
- Undefined: `valid[i]` pulses on every toggle.
- The hit map, serializer and `covered` are identical in both builds.

## Structure
- Shared package `toggle_cover_pkg`: `COVER_IDX_W`=64, state enum `tc_ser_state_e` {IDLE, PRESENT}, and `COVER_TOTAL` default constant.
- Sub-module `toggle_cover_prio_enc` (WIDTH-in, lowest-set index plus any-set flag). It is reused by the collector.
- Top: edge detect, hit/pending regs, serializer FSM, popcount.

## Test plan
- WIDTH=9, COVER_INDEX=100; release reset with sig=0x1FF held → `valid` stays 0 and `evt_valid` stays 0 (priming).
- sig 0x000→0x005 with enable=1, `evt_ready`=1 → `valid`=0x005 one cycle later. Then events 100 and 102, in that order, each presented for 1 cycle; `covered`=2.
- `evt_ready`=0 for 10 cycles while bit 3 then bit 1 toggle → `evt_index` holds the first latched index (103) stable. After ready, events 101 follow; no event is lost or duplicated.
- Toggle bit 4 three times: without the macro `valid[4]` pulses 3 times; with `TOGGLE_COVER_FIRST_ONLY_EN` it pulses once. Exactly one event, index 104, in both builds.
- `clear` while PRESENT with index 100 unaccepted → `evt_valid`=0 next cycle and `covered`=0. A re-toggle of bit 0 regenerates index 100.
- enable=0 while sig toggles all bits → no valid and no events. Re-enable with sig unchanged → still none.
